// File: rtl/output_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_drain_pkg
// Description : Shared types and constants for the output drain stage.
//               Holds the drain FSM state encoding, the output-buffer port
//               control words, and the default widths shared with the array
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package output_drain_pkg;

    // Default widths, shared with the array controller
    localparam int DRAIN_DATA_W = 16;
    localparam int DRAIN_ADDR_W = 6;
    localparam int DRAIN_FIFO_D = 2;

    // Drain FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } drain_state_t;

    // Output-buffer control word (wen/cen active-low, ren active-high)
    typedef struct packed {
        logic wen;
        logic ren;
        logic cen;
    } buf_ctrl_t;

    localparam buf_ctrl_t BUF_IDLE = '{wen: 1'b1, ren: 1'b0, cen: 1'b1};
    localparam buf_ctrl_t BUF_READ = '{wen: 1'b1, ren: 1'b1, cen: 1'b0};

    // A new read may issue when the words already held plus the one in
    // flight leave a free FIFO slot. A pop in the same cycle frees a slot
    // in time for the word that would be captured next cycle, which is
    // what lets the stream sustain one word per cycle.
    function automatic logic credit_ok(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop,
                                       input int         depth);
        return (int'(count) + int'(inflight)) < (depth + int'(pop));
    endfunction

endpackage : output_drain_pkg
`default_nettype wire

// File: rtl/output_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : output_drain_if
// Description : Bus bundle of the output drain stage: the output-buffer
//               read port and the valid/ready result stream to the host.
//               master - the drain stage (drives buffer control, stream out)
//               slave  - the buffer/host side
// Signals     : output_wen/ren/cen/addr  buffer control (wen, cen active-low)
//               output_q                 buffer read data (1-cycle latency)
//               M_DATA/M_VALID/M_LAST    stream out
//               M_READY                  stream backpressure
// Revision    : 1.0 - initial release
// ============================================================================
interface output_drain_if
    import output_drain_pkg::*;
#(
    parameter int DATA_W = DRAIN_DATA_W,
    parameter int ADDR_W = DRAIN_ADDR_W
) ();

    logic              output_wen;
    logic              output_ren;
    logic              output_cen;
    logic [ADDR_W-1:0] output_addr;
    logic [DATA_W-1:0] output_q;

    logic [DATA_W-1:0] M_DATA;
    logic              M_VALID;
    logic              M_READY;
    logic              M_LAST;

    modport master (
        output output_wen,
        output output_ren,
        output output_cen,
        output output_addr,
        input  output_q,
        output M_DATA,
        output M_VALID,
        output M_LAST,
        input  M_READY
    );

    modport slave (
        input  output_wen,
        input  output_ren,
        input  output_cen,
        input  output_addr,
        output output_q,
        input  M_DATA,
        input  M_VALID,
        input  M_LAST,
        output M_READY
    );

endinterface : output_drain_if
`default_nettype wire

// File: rtl/output_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : drain_fifo
// Description : Two-entry registered skid FIFO. Slot 0 is always the head,
//               so the head output comes straight from a register.
// Ports       : CLK        clock
//               RESET      asynchronous active-low reset
//               push       write push_data this cycle
//               push_data  word to write
//               pop        remove the head this cycle (ignored when empty)
//               count      number of words held (0..2)
//               head       oldest word held
// Revision    : 1.0 - initial release
// ============================================================================
module drain_fifo #(
    parameter int DATA_W = 16
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    input  wire logic              pop,
    output logic      [1:0]        count,
    output logic      [DATA_W-1:0] head
);

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_slot0;
    logic [DATA_W-1:0] r_slot1;
    logic              w_pop;

    assign w_pop = pop && (r_count != 2'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= push_data;
                    end else begin
                        r_slot1 <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the incoming word lands behind
                    // whatever survives the pop.
                    if (r_count == 2'd1) begin
                        r_slot0 <= push_data;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_slot0;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET)
        !(push && !w_pop && (r_count == 2'd2)));
`endif

endmodule : drain_fifo
`default_nettype wire

// File: rtl/output_drain.sv
`default_nettype none
// ============================================================================
// Module      : output_drain
// Description : Reads a result block out of the output buffer after a run
//               and streams it to the host over valid/ready. Handles the
//               buffer's 1-cycle read latency and absorbs host backpressure
//               in a 2-entry skid FIFO with credit-based read issue.
// Ports       : CLK        clock
//               RESET      asynchronous active-low reset
//               EN         global enable (low: no new reads, state held)
//               START      one-cycle start pulse (accepted only in IDLE)
//               BASE_ADDR  first output-buffer word
//               LEN        number of words (0 = nothing to drain)
//               BUSY       high from accepted START until DONE
//               DONE       one-cycle pulse after the last word is accepted
//               bus        output_drain_if master (buffer port + stream)
// Revision    : 1.0 - initial release
// ============================================================================
module output_drain
    import output_drain_pkg::*;
#(
    parameter int DATA_W = DRAIN_DATA_W,
    parameter int ADDR_W = DRAIN_ADDR_W,
    parameter int FIFO_D = DRAIN_FIFO_D
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    input  wire logic              EN,
    input  wire logic              START,
    input  wire logic [ADDR_W-1:0] BASE_ADDR,
    input  wire logic [ADDR_W-1:0] LEN,
    output logic                   BUSY,
    output logic                   DONE,
    output_drain_if.master         bus
);

    drain_state_t      r_state;
    drain_state_t      w_state_nxt;

    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_emitted;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              r_inflight;
    logic              r_busy;

    logic              w_start;
    logic              w_first;
    logic              w_issue;
    logic              w_valid;
    logic              w_pop;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [ADDR_W-1:0] w_issue_rem;
    logic [1:0]        w_count;
    logic [DATA_W-1:0] w_head;
    buf_ctrl_t         w_ctrl;

    // ------------------------------------------------------------------
    // Issue decision
    // ------------------------------------------------------------------
    assign w_start = (r_state == IDLE) && START && EN;

    // The first read goes out in the START cycle itself, straight from
    // BASE_ADDR; the FIFO is empty and nothing is in flight in IDLE, so
    // it always has credit. This gives first data two cycles after START.
    assign w_first = w_start && (LEN != '0);

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && bus.M_READY;

    assign w_issue = w_first ||
                     ((r_state == READ) && EN && (r_remaining != '0) &&
                      credit_ok(w_count, r_inflight, w_pop, FIFO_D));

    assign w_issue_addr = w_first ? BASE_ADDR : r_rd_addr;
    assign w_issue_rem  = w_first ? LEN : r_remaining;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (LEN == '0) begin
                        w_state_nxt = FIN;
                    end else if (LEN == ADDR_W'(1)) begin
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (w_issue && (r_remaining == ADDR_W'(1))) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Leave as the final word is being accepted so that DONE
                // lands in the very next cycle.
                if (EN && !r_inflight &&
                    ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop))) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address, count and credit registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_emitted   <= '0;
            r_addr_hold <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Set on issue, cleared the cycle after: marks output_q valid.
            r_inflight <= w_issue;

            if (w_pop) begin
                r_emitted <= r_emitted + ADDR_W'(1);
            end

            if (w_start) begin
                r_rd_addr   <= BASE_ADDR;
                r_remaining <= LEN;
                r_len       <= LEN;
                r_emitted   <= '0;
                r_busy      <= 1'b1;
            end

            // Address wraps naturally modulo 2^ADDR_W.
            if (w_issue) begin
                r_rd_addr   <= w_issue_addr + ADDR_W'(1);
                r_remaining <= w_issue_rem - ADDR_W'(1);
                r_addr_hold <= w_issue_addr;
            end

            if (r_state == FIN) begin
                r_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid FIFO: captures output_q the cycle after every issue,
    // regardless of EN, since the buffer has already been read.
    // ------------------------------------------------------------------
    drain_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (r_inflight),
        .push_data (bus.output_q),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_ctrl          = w_issue ? BUF_READ : BUF_IDLE;
    assign bus.output_wen  = w_ctrl.wen;
    assign bus.output_ren  = w_ctrl.ren;
    assign bus.output_cen  = w_ctrl.cen;
    assign bus.output_addr = w_issue ? w_issue_addr : r_addr_hold;

    assign bus.M_VALID = w_valid;
    assign bus.M_DATA  = w_head;
    assign bus.M_LAST  = w_valid && (r_emitted == (r_len - ADDR_W'(1)));

    assign BUSY = r_busy;
    assign DONE = (r_state == FIN);

`ifndef SYNTHESIS
    a_credit: assert property (@(posedge CLK) disable iff (!RESET)
        (int'(w_count) + int'(r_inflight)) <= FIFO_D);
`endif

endmodule : output_drain
`default_nettype wire

// File: tb/tb_output_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_drain
// Description : Directed self-checking bench for output_drain. A behavioural
//               buffer model holds addr*3 at every address; each scenario
//               checks the streamed words, handshake timing and buffer
//               port activity against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_drain;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          EN;
    logic          START;
    logic [AW-1:0] BASE_ADDR;
    logic [AW-1:0] LEN;
    logic          BUSY;
    logic          DONE;

    always #5 CLK = ~CLK;

    output_drain_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    output_drain #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .FIFO_D (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .START     (START),
        .BASE_ADDR (BASE_ADDR),
        .LEN       (LEN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .bus       (bus)
    );

    // Output buffer model: 1-cycle read latency
    logic [DW-1:0] mem [64];
    logic [DW-1:0] r_q;
    always @(posedge CLK) begin
        if (!bus.output_cen && bus.output_ren) r_q <= mem[bus.output_addr];
    end
    assign bus.output_q = r_q;

    // Bookkeeping
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            start_cyc;
    logic [DW-1:0] bq_data [$];
    bit            bq_last [$];
    int            bq_cyc  [$];
    logic [AW-1:0] iss_addr[$];
    int            done_q  [$];
    int            valid_cnt, busy_cnt, stall_err, outst_err;
    int            beats_en_off, iss_en_off;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    bit            rdy_rand;
    bit            rdy_fixed;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic mon_clear();
        bq_data.delete(); bq_last.delete(); bq_cyc.delete();
        iss_addr.delete(); done_q.delete();
        valid_cnt = 0; busy_cnt = 0; stall_err = 0; outst_err = 0;
        beats_en_off = 0; iss_en_off = 0; prev_stall = 1'b0;
    endtask

    // One clock: sample on the falling edge, then change inputs 1 time
    // unit after the rising edge.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (bus.M_VALID && bus.M_READY) begin
            bq_data.push_back(bus.M_DATA);
            bq_last.push_back(bus.M_LAST);
            bq_cyc.push_back(cyc);
            if (!EN) beats_en_off++;
        end
        if (!bus.output_cen) begin
            iss_addr.push_back(bus.output_addr);
            if (!EN) iss_en_off++;
        end
        if (bus.M_VALID) valid_cnt++;
        if (BUSY) busy_cnt++;
        if (DONE) done_q.push_back(cyc);
        if (prev_stall && (!bus.M_VALID || bus.M_DATA != prev_data)) stall_err++;
        prev_stall = bus.M_VALID && !bus.M_READY;
        prev_data  = bus.M_DATA;
        if (iss_addr.size() - bq_data.size() > 2) outst_err++;
        @(posedge CLK);
        #1;
        if (rdy_rand) bus.M_READY = ($urandom_range(0, 9) >= 3);
        else          bus.M_READY = rdy_fixed;
    endtask

    task automatic start_drain(input int base, input int len);
        BASE_ADDR = AW'(base);
        LEN       = AW'(len);
        START     = 1'b1;
        start_cyc = cyc + 1;
        tick();
        START     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done_q.size() != 0) break;
            tick();
        end
        check_value({tag, "_done_seen"}, done_q.size() != 0, 1);
    endtask

    task automatic verify_stream(input string tag, input int base, input int len);
        int derr = 0;
        int lerr = 0;
        int aerr = 0;
        logic [DW-1:0] exp_d;
        logic [AW-1:0] exp_a;
        check_value({tag, "_beats"}, bq_data.size(), len);
        check_value({tag, "_reads"}, iss_addr.size(), len);
        for (int i = 0; i < bq_data.size(); i++) begin
            exp_d = DW'(((base + i) % 64) * 3);
            if (bq_data[i] !== exp_d) derr++;
            if (bq_last[i] != (i == len - 1)) lerr++;
        end
        for (int i = 0; i < iss_addr.size(); i++) begin
            exp_a = AW'((base + i) % 64);
            if (iss_addr[i] !== exp_a) aerr++;
        end
        check_value({tag, "_data_err"}, derr, 0);
        check_value({tag, "_last_err"}, lerr, 0);
        check_value({tag, "_addr_err"}, aerr, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_wen"},   bus.output_wen,  1);
        check_value({tag, "_ren"},   bus.output_ren,  0);
        check_value({tag, "_cen"},   bus.output_cen,  1);
        check_value({tag, "_addr"},  bus.output_addr, 0);
        check_value({tag, "_valid"}, bus.M_VALID,     0);
        check_value({tag, "_data"},  bus.M_DATA,      0);
        check_value({tag, "_last"},  bus.M_LAST,      0);
        check_value({tag, "_busy"},  BUSY,            0);
        check_value({tag, "_done"},  DONE,            0);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = DW'(a * 3);
        RESET = 1'b0; EN = 1'b1; START = 1'b0;
        BASE_ADDR = '0; LEN = '0;
        rdy_rand = 1'b0; rdy_fixed = 1'b1; bus.M_READY = 1'b1;

        // ---- reset state ----
        @(posedge CLK); #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        tick();

        // ---- 1: BASE 0, LEN 32, always ready ----
        mon_clear();
        start_drain(0, 32);
        wait_done("t1", 200);
        tick();
        verify_stream("t1", 0, 32);
        check_value("t1_first_beat_rel", (bq_cyc.size() != 0) ? bq_cyc[0] - start_cyc : -1, 2);
        check_value("t1_last_beat_rel",  (bq_cyc.size() == 32) ? bq_cyc[31] - start_cyc : -1, 33);
        check_value("t1_last_data", (bq_data.size() == 32) ? 32'(bq_data[31]) : 0, 93);
        check_value("t1_done_rel", (done_q.size() != 0) ? done_q[0] - start_cyc : -1, 34);
        check_value("t1_done_pulses", done_q.size(), 1);
        check_value("t1_busy_cycles", busy_cnt, 34);
        check_value("t1_busy_after", BUSY, 0);
        check_value("t1_outstanding", outst_err, 0);

        // ---- 2: BASE 60, LEN 8, address wrap ----
        mon_clear();
        start_drain(60, 8);
        wait_done("t2", 100);
        verify_stream("t2", 60, 8);
        check_value("t2_beat4_data", (bq_data.size() > 4) ? 32'(bq_data[4]) : 32'hFFFF, 0);
        check_value("t2_beat3_data", (bq_data.size() > 3) ? 32'(bq_data[3]) : 32'hFFFF, 189);

        // ---- 3: LEN 16 with random backpressure ----
        mon_clear();
        rdy_rand = 1'b1;
        start_drain(10, 16);
        wait_done("t3", 400);
        rdy_rand = 1'b0; rdy_fixed = 1'b1; bus.M_READY = 1'b1;
        verify_stream("t3", 10, 16);
        check_value("t3_stall_stable", stall_err, 0);
        check_value("t3_outstanding", outst_err, 0);
        check_value("t3_done_pulses", done_q.size(), 1);

        // ---- 4: LEN 0 ----
        tick();
        mon_clear();
        start_drain(7, 0);
        wait_done("t4", 20);
        tick();
        check_value("t4_done_rel", (done_q.size() != 0) ? done_q[0] - start_cyc : -1, 1);
        check_value("t4_reads", iss_addr.size(), 0);
        check_value("t4_valid_cycles", valid_cnt, 0);

        // ---- 5: ignored second START, EN low for 5 cycles ----
        mon_clear();
        start_drain(20, 12);
        repeat (3) tick();
        BASE_ADDR = AW'(40); LEN = AW'(3); START = 1'b1;
        tick();
        START = 1'b0;
        EN = 1'b0;
        repeat (5) tick();
        EN = 1'b1;
        wait_done("t5", 100);
        verify_stream("t5", 20, 12);
        check_value("t5_reads_en_low", iss_en_off, 0);
        check_value("t5_beats_en_low", beats_en_off, 2);
        check_value("t5_done_pulses", done_q.size(), 1);

        // ---- 6: reset with a word buffered and a read in flight ----
        tick();
        mon_clear();
        rdy_fixed = 1'b0; bus.M_READY = 1'b0;
        start_drain(0, 10);
        tick();
        RESET = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        mon_clear();
        repeat (2) tick();
        RESET = 1'b1;
        rdy_fixed = 1'b1; bus.M_READY = 1'b1;
        repeat (4) tick();
        check_value("t6_valid_after_rst", valid_cnt, 0);
        mon_clear();
        start_drain(5, 4);
        wait_done("t6", 50);
        verify_stream("t6", 5, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_output_drain
`default_nettype wire
